// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_pkg
//  Description : Shared types and widths for the instruction-sequencing
//                controller: state encoding, default bus widths, counter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W_DEFAULT = 8;
  localparam int RETIRED_W      = 8;
  localparam int WDOG_W         = 8;

  // Encoding is visible on state_dbg, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_watchdog
//  Description : Counts FETCH cycles without acknowledge. 'expired' flags the
//                cycle in which the count would reach 'limit' with no ack, so
//                the controller can fault at the end of that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_watchdog
  import fetch_ctrl_pkg::*;
#(
  parameter int CNT_W = WDOG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_en,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // This cycle is the limit-th unacknowledged one.
  assign expired = count_en && ((cnt_q + CNT_W'(1)) == limit);

  // Next count: zero while cleared, otherwise advance on each waiting cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction-sequencing controller. Fetches over req/ack,
//                hands each instruction to execute, steps the PC (with branch
//                offset), and handles halt and fetch-timeout faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEFAULT,
  parameter int DATA_W        = DATA_W_DEFAULT,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                 CLK,
  input  logic                 areset,
  input  logic                 run,
  input  logic [ADDR_W-1:0]    pc_addr,
  output logic                 pc_step,
  output logic                 pc_offset_sel,
  output logic [ADDR_W-1:0]    pc_offset,
  output logic                 imem_req,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic                 imem_ack,
  input  logic [DATA_W-1:0]    imem_data,
  output logic [DATA_W-1:0]    ir,
  input  logic                 halt_req,
  output logic                 ex_start,
  input  logic                 ex_done,
  input  logic                 br_taken,
  input  logic [ADDR_W-1:0]    br_offset,
  output logic                 halted,
  output logic                 fault,
  output logic [RETIRED_W-1:0] retired,
  output logic [2:0]           state_dbg
);

  localparam logic [WDOG_W-1:0] c_limit = WDOG_W'(FETCH_TIMEOUT);

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     ir_q, ir_d;
  logic                  pc_step_q, pc_step_d;
  logic                  pc_offset_sel_q, pc_offset_sel_d;
  logic [ADDR_W-1:0]     pc_offset_q, pc_offset_d;
  logic                  ex_start_q, ex_start_d;
  logic                  halted_q, halted_d;
  logic                  fault_q, fault_d;
  logic [RETIRED_W-1:0]  retired_q, retired_d;

  logic                  w_in_fetch;
  logic                  w_expired;

  assign w_in_fetch = (state_q == ST_FETCH);

  // The watchdog sits at zero outside FETCH, so every FETCH entry starts fresh.
  fetch_watchdog #(
    .CNT_W (WDOG_W)
  ) u_watchdog (
    .clk      (CLK),
    .rst      (areset),
    .clear    (!w_in_fetch),
    .count_en (w_in_fetch && !imem_ack),
    .limit    (c_limit),
    .expired  (w_expired)
  );

  // Fetch request is combinational so the address tracks the PC register.
  assign imem_req      = w_in_fetch;
  assign imem_addr     = w_in_fetch ? pc_addr : '0;

  assign pc_step       = pc_step_q;
  assign pc_offset_sel = pc_offset_sel_q;
  assign pc_offset     = pc_offset_q;
  assign ir            = ir_q;
  assign ex_start      = ex_start_q;
  assign halted        = halted_q;
  assign fault         = fault_q;
  assign retired       = retired_q;
  assign state_dbg     = state_q;

  // Next-state and registered-output decode; pulses are set on entry to the
  // state in which they must be visible.
  always_comb begin
    state_d         = state_q;
    ir_d            = ir_q;
    pc_step_d       = 1'b0;
    pc_offset_sel_d = pc_offset_sel_q;
    pc_offset_d     = pc_offset_q;
    ex_start_d      = 1'b0;
    halted_d        = halted_q;
    fault_d         = fault_q;
    retired_d       = retired_q;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Ack in the expiry cycle still wins.
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_DECODE;
        end else if (w_expired) begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (halt_req) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          ex_start_d = 1'b1;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Branch result is captured straight into the offset outputs.
        if (ex_done) begin
          pc_step_d       = 1'b1;
          pc_offset_sel_d = br_taken;
          pc_offset_d     = br_taken ? br_offset : '0;
          state_d         = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        pc_offset_sel_d = 1'b0;
        pc_offset_d     = '0;
        retired_d       = retired_q + RETIRED_W'(1);
        state_d         = ST_FETCH;
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset overrides any pending ack or done.
  always_ff @(posedge CLK) begin
    if (areset) begin
      state_q         <= ST_IDLE;
      ir_q            <= '0;
      pc_step_q       <= 1'b0;
      pc_offset_sel_q <= 1'b0;
      pc_offset_q     <= '0;
      ex_start_q      <= 1'b0;
      halted_q        <= 1'b0;
      fault_q         <= 1'b0;
      retired_q       <= '0;
    end else begin
      state_q         <= state_d;
      ir_q            <= ir_d;
      pc_step_q       <= pc_step_d;
      pc_offset_sel_q <= pc_offset_sel_d;
      pc_offset_q     <= pc_offset_d;
      ex_start_q      <= ex_start_d;
      halted_q        <= halted_d;
      fault_q         <= fault_d;
      retired_q       <= retired_d;
    end
  end

endmodule
`default_nettype wire
